// File: rtl/cpu_bus_pkg.sv
// Shared definitions for the data-side SRAM-like bridge: FSM states,
// bus transfer size codes and the byte-enable to size mapping.
package cpu_bus_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DONE
  } bridge_state_e;

  localparam logic [1:0] SZ_BYTE  = 2'b00;
  localparam logic [1:0] SZ_HALF  = 2'b01;
  localparam logic [1:0] SZ_WORD  = 2'b10;
  localparam logic [1:0] SZ_DWORD = 2'b11;

  // wen is zero-extended to 8 lanes; reads and irregular patterns take the widest size.
  function automatic logic [1:0] wen_to_size(input logic [7:0] wen, input logic wide);
    logic [3:0] ones;
    logic [1:0] size;
    ones = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      ones = ones + {3'b000, wen[i]};
    end
    if (ones == 4'd1) begin
      size = SZ_BYTE;
    end else if (wen inside {8'h03, 8'h0C, 8'h30, 8'hC0}) begin
      size = SZ_HALF;
    end else if (wen inside {8'h0F, 8'hF0}) begin
      size = SZ_WORD;
    end else if (wen == 8'hFF) begin
      size = SZ_DWORD;
    end else begin
      size = wide ? SZ_DWORD : SZ_WORD;
    end
    return size;
  endfunction

endpackage

// File: rtl/tag_fifo.sv
// In-order FIFO of 1-bit tags for accepted-but-unreturned bus transactions.
// DEPTH must be a power of two so the pointers wrap naturally.
module tag_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic                         push_tag,
  input  logic                         pop,
  output logic                         pop_tag,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [DEPTH-1:0] mem_q, mem_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is still accepted.
  assign do_push = push & (~full | do_pop);
  assign pop_tag = mem_q[rd_ptr_q];
  assign count   = cnt_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_tag;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (do_push && !do_pop) begin
      cnt_d = cnt_q + CW'(1);
    end else if (do_pop && !do_push) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/sramlike_dbridge.sv
// Data-side bridge from the pipeline's single-cycle SRAM port to the SRAM-like bus.
// Define SRAMLIKE_POSTED_WR_EN to let writes complete to the pipeline at addr_ok.
module sramlike_dbridge
  import cpu_bus_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned MAX_OUT = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         data_sram_en,
  input  logic [ADDR_W-1:0]            data_sram_addr,
  input  logic [DATA_W/8-1:0]          data_sram_wen,
  input  logic [DATA_W-1:0]            data_sram_wdata,
  output logic [DATA_W-1:0]            data_sram_rdata,
  output logic                         d_stall,
  input  logic                         pipe_hold,
  output logic                         data_req,
  output logic                         data_wr,
  output logic [1:0]                   data_size,
  output logic [ADDR_W-1:0]            data_addr,
  output logic [DATA_W-1:0]            data_wdata,
  input  logic [DATA_W-1:0]            data_rdata,
  input  logic                         data_addr_ok,
  input  logic                         data_data_ok,
  output logic [$clog2(MAX_OUT+1)-1:0] out_cnt
);

  localparam int unsigned NB   = DATA_W / 8;
  localparam int unsigned CW   = $clog2(MAX_OUT + 1);
  localparam logic        WIDE = (DATA_W == 64);
`ifdef SRAMLIKE_POSTED_WR_EN
  localparam logic POSTED_WR = 1'b1;
`else
  localparam logic POSTED_WR = 1'b0;
`endif

  bridge_state_e     state_q, state_d;
  logic              wr_q, wr_d;
  logic [1:0]        size_q, size_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic [7:0]        wen8;
  logic              fifo_push, fifo_full, fifo_empty, head_is_read;
  logic [CW-1:0]     fifo_cnt;

  assign fifo_push = (state_q == REQ) & data_addr_ok;

  tag_fifo #(
    .DEPTH (MAX_OUT)
  ) u_tag_fifo (
    .clk      (clk),
    .rst_n    (rst),
    .push     (fifo_push),
    .push_tag (~wr_q),
    .pop      (data_data_ok),
    .pop_tag  (head_is_read),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_cnt)
  );

  always_comb begin
    wen8         = '0;
    wen8[NB-1:0] = data_sram_wen;
  end

  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    size_d  = size_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (data_sram_en && !fifo_full) begin
          state_d = REQ;
          wr_d    = |data_sram_wen;
          size_d  = wen_to_size(wen8, WIDE);
          addr_d  = data_sram_addr;
          wdata_d = data_sram_wdata;
        end
      end
      REQ: begin
        if (data_addr_ok) begin
          state_d = (POSTED_WR && wr_q) ? DONE : WAIT;
        end
      end
      WAIT: begin
        // Own tag is the youngest entry, so it is at the head only when it is alone.
        if (data_data_ok && fifo_cnt == CW'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (!pipe_hold) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (data_data_ok && !fifo_empty && head_is_read) begin
      rdata_d = data_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      wr_q    <= 1'b0;
      size_q  <= SZ_BYTE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  assign data_req        = (state_q == REQ);
  assign data_wr         = wr_q;
  assign data_size       = size_q;
  assign data_addr       = addr_q;
  assign data_wdata      = wdata_q;
  assign data_sram_rdata = rdata_q;
  assign d_stall         = data_sram_en & (state_q != DONE);
  assign out_cnt         = fifo_cnt;

endmodule

// File: doc/sramlike_dbridge.md
Name: sramlike_dbridge

Overview:
Parametrised data-side bridge from the pipeline's single-cycle SRAM-style port to the SRAM-like (req/addr_ok/data_ok) bus. It supersedes the single-outstanding data bridge with the following additions:
- configurable data and address widths;
- an in-order outstanding-transaction tracker, so that data_ok is never mis-attributed;
- one merged pipeline-hold input;
- optional posted writes.

It sits between MEM stage and the AXI/SRAM-like interconnect.

Parameters:
DATA_W, 32, data bus width (32 or 64)
ADDR_W, 32, address width
MAX_OUT, 4, max accepted-but-unreturned transactions (power of 2, >=2)

Ports:
clk  in  1  clock
rst  in  1  reset; one clock; reset is asynchronous and active-low
data_sram_en  in  1  pipeline access request, level, held while stalled
data_sram_addr  in  ADDR_W  access address
data_sram_wen  in  DATA_W/8  byte write enables; all-zero = read
data_sram_wdata  in  DATA_W  write data
data_sram_rdata  out  DATA_W  last read data, held until next read returns
d_stall  out  1  pipeline must stall for this access
pipe_hold  in  1  pipeline frozen for another reason (div, gap, etc.)
data_req  out  1  SRAM-like request
data_wr  out  1  1 = write
data_size  out  2  00 byte, 01 half, 10 word, 11 dword (DATA_W=64 only)
data_addr  out  ADDR_W  = data_sram_addr
data_wdata  out  DATA_W  = data_sram_wdata
data_rdata  in  DATA_W  returned read data
data_addr_ok  in  1  address handshake
data_data_ok  in  1  data handshake, strictly in request order
out_cnt  out  $clog2(MAX_OUT+1)  current outstanding count (debug / flush sync)

Behaviour:
- Reset values: state IDLE, tracker empty, out_cnt=0, data_sram_rdata=0, data_req=0. Reset clears the tracker only; the slave is reset by the same rst.
- FSM states are IDLE, REQ, WAIT, DONE. data_req = (state==REQ).
- IDLE -> REQ when data_sram_en & ~full. full = (out_cnt==MAX_OUT).
- REQ -> push tag {is_read} on data_addr_ok. Next state: WAIT, or DONE for a posted write (see Optional Feature).
- In REQ, data_wr, data_size, data_addr and data_wdata are held stable until data_addr_ok.
- WAIT -> DONE on the data_ok that pops this access's own tag, i.e. data_ok while out_cnt==1 (own entry is at the tail).
- DONE -> IDLE when ~pipe_hold. While in DONE, no request is issued even if data_sram_en stays high.
- d_stall = data_sram_en & (state!=DONE). If data_sram_en=0, the FSM stays in IDLE.
- Tracker: MAX_OUT-entry 1-bit FIFO. Push on data_req&data_addr_ok; pop on data_data_ok.
  - Simultaneous push and pop: the pop applies to the older head entry, and out_cnt is unchanged.
- data_sram_rdata is loaded with data_rdata on data_data_ok when the popped head tag is a read. Write returns never disturb it.
- data_size mapping from the popcount of wen:
  - popcount 1 -> 00;
  - 2 contiguous aligned -> 01;
  - 4 aligned -> 10;
  - 8 -> 11;
  - read -> 10 for DATA_W=32, 11 for DATA_W=64;
  - any other pattern -> widest size.
- data_data_ok with empty tracker: ignored, tracker does not underflow.
- A read never passes a pending write; the slave's in-order return guarantees this. No extra logic is needed beyond FIFO order.
- Latency: the request appears 1 cycle after data_sram_en rises (IDLE->REQ). d_stall drops in the cycle after the completing handshake.

Optional Feature:
SRAMLIKE_POSTED_WR_EN
- Defined: a write completes to the pipeline at addr_ok (REQ->DONE directly), so d_stall drops without waiting for data_ok. Up to MAX_OUT writes may be in flight. A following read enters WAIT and completes only when out_cnt returns to 1 with its own tag at the head.
- Undefined: every access waits for data_ok, and out_cnt never exceeds 1. MAX_OUT is then irrelevant but still legal.

Decomposition:
- Shared package (cpu_bus_pkg) holds:
  - the FSM state enum;
  - the size codes SZ_BYTE/SZ_HALF/SZ_WORD/SZ_DWORD;
  - the wen->size function.
- One sub-module, tag_fifo: a parametrised 1-bit-wide in-order FIFO with push/pop/full/empty/count, using async active-low reset.

Test Plan:
- Single read: en=1, wen=0, addr=0x100; addr_ok at cycle 2, data_ok with 0xDEADBEEF at cycle 5. Required: one req pulse, d_stall high for cycles 0-5, rdata=0xDEADBEEF from cycle 6.
- Read under pipe_hold: same as above but pipe_hold=1 for 10 more cycles. Required: exactly one data_req, d_stall=0 during the hold, rdata stable.
- Byte write: wen=0100, wdata=0x00AA0000. Required: data_wr=1, data_size=00. With the macro undefined, d_stall stays high until data_ok.
- Posted writes (macro defined): 4 back-to-back writes with data_ok withheld. Required: out_cnt=4, the 5th request blocked (data_req=0, d_stall=1) until the first data_ok.
- Write then read, with the read's addr_ok in the same cycle as the write's data_ok. Required: out_cnt stays 1, rdata is not updated by the write return, and the read completes on the next data_ok with its value.
- Async reset (rst=0) asserted mid-WAIT. Required: immediately IDLE, data_req=0, out_cnt=0, rdata=0.
